// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scan path.
package disp_pkg;

    localparam int NDIG = 4;

    // All anodes off (active-low).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Single-bit seed shifted by the digit index to form the one-hot anode pattern.
    localparam logic [3:0] AN_ONEHOT_BASE = 4'b0001;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_idx_t;

    // Active-low one-hot-zero anode pattern for a digit index.
    function automatic logic [3:0] an_encode(input logic [1:0] idx);
        return ~(AN_ONEHOT_BASE << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit write port and scan outputs of the display scan controller.
interface display_scan_ctrl_if;
    import disp_pkg::*;

    logic   en;
    logic   wr_en;
    logic   [1:0] wr_addr;
    digit_t wr_data;

    digit_t a0;
    digit_t a1;
    digit_t a2;
    digit_t a3;
    logic   S1;
    logic   S0;
    logic   [3:0] AN;
    logic   frame_tick;

    // Driver side: enables the scan and writes digit values, observes the display drive.
    modport master (
        output en,
        output wr_en,
        output wr_addr,
        output wr_data,
        input  a0,
        input  a1,
        input  a2,
        input  a3,
        input  S1,
        input  S0,
        input  AN,
        input  frame_tick
    );

    // Controller side.
    modport slave (
        input  en,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output a0,
        output a1,
        output a2,
        output a3,
        output S1,
        output S0,
        output AN,
        output frame_tick
    );

endinterface

// File: rtl/display_scan_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every DIV enabled clocks. Freezes (does not clear) while en=0.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] presc;

    // Terminal count only counts as a tick while enabled, so a frozen prescaler
    // sitting on LAST does not fire repeatedly.
    assign tick = en && (presc == LAST);

    // Count 0..DIV-1 and wrap while enabled; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (en) begin
            if (presc == LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + CW'(1);
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Round-robin scan controller for a 4-digit multiplexed 7-segment display.
// Digit writes land in a shadow bank; the visible bank is swapped in only at the
// frame wrap so a frame never shows a mix of old and new digits.
//
//  state | meaning
//  ------+-----------------------------------------------
//  DIG0  | digit 0 slot, AN=1110, first slot of a frame
//  DIG1  | digit 1 slot, AN=1101
//  DIG2  | digit 2 slot, AN=1011
//  DIG3  | digit 3 slot, AN=0111; tick here commits bank
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);

    logic     tick;
    dig_idx_t idx;
    dig_idx_t idx_next;
    logic     commit;

    digit_t   shadow      [NDIG];
    digit_t   shadow_next [NDIG];
    digit_t   disp_q      [NDIG];
    logic [1:0] sel_q;
    logic [3:0] an_q;
    logic       frame_tick_q;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .tick (tick)
    );

    // Digit index state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= DIG0;
        end else begin
            idx <= idx_next;
        end
    end

    // Advance one slot per tick; a tick leaving DIG3 is the frame boundary.
    always_comb begin
        idx_next = idx;
        commit   = 1'b0;
        if (tick) begin
            unique case (idx)
                DIG0: idx_next = DIG1;
                DIG1: idx_next = DIG2;
                DIG2: idx_next = DIG3;
                DIG3: begin
                    idx_next = DIG0;
                    commit   = 1'b1;
                end
                default: idx_next = DIG0;
            endcase
        end
    end

    // Shadow bank with this cycle's write folded in, so a write in the commit
    // cycle still makes it into the frame being committed.
    always_comb begin
        shadow_next = shadow;
        if (bus.wr_en) begin
            shadow_next[bus.wr_addr] = bus.wr_data;
        end
    end

    // Shadow bank register; last write to an address before commit wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            shadow <= shadow_next;
        end
    end

    // Visible bank: swapped atomically at the frame boundary only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                disp_q[i] <= '0;
            end
        end else if (commit) begin
            disp_q <= shadow_next;
        end
    end

    // Registered mux select, anodes and frame pulse, all aligned to idx_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= 2'b00;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            sel_q        <= idx_next;
            an_q         <= bus.en ? an_encode(idx_next) : AN_OFF;
            frame_tick_q <= commit;
        end
    end

    assign bus.a0         = disp_q[0];
    assign bus.a1         = disp_q[1];
    assign bus.a2         = disp_q[2];
    assign bus.a3         = disp_q[3];
    assign bus.S1         = sel_q[1];
    assign bus.S0         = sel_q[0];
    assign bus.AN         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIV=4 (one slot = 4 clks, one frame = 16 clks).
// Stimulus pushes the expected committed bank for each frame; the monitor pops and
// compares whenever frame_tick is seen.
module tb_display_scan_ctrl;
    import disp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [3:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    // Monitor: each frame_tick must match the next expected bank, with select at 00
    // and digit 0 lit.
    always @(negedge clk) begin
        if (!rst && bus.frame_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got frame_tick=1 expected none at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("frame_bank", {bus.a3, bus.a2, bus.a1, bus.a0}, mon_exp);
                chk("frame_sel", {14'd0, bus.S1, bus.S0}, 16'd0);
                chk("frame_an", {12'd0, bus.AN}, 16'h000E);
            end
        end
    end

    initial begin
        bus.en      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 4'd0;

        // 1: async reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_bank", {bus.a3, bus.a2, bus.a1, bus.a0}, 16'h0000);
        chk("rst_sel", {14'd0, bus.S1, bus.S0}, 16'd0);
        chk("rst_an", {12'd0, bus.AN}, 16'h000F);
        chk("rst_ft", {15'd0, bus.frame_tick}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.en = 1'b1;

        // 2: free-running scan, frame 1 ends at edge 16
        exp_q.push_back(16'h0000);
        step(1);
        chk("scan_e1_an", {12'd0, bus.AN}, 16'h000E);
        chk("scan_e1_sel", {14'd0, bus.S1, bus.S0}, 16'd0);
        step(3);
        chk("scan_e4_an", {12'd0, bus.AN}, 16'h000D);
        chk("scan_e4_sel", {14'd0, bus.S1, bus.S0}, 16'd1);
        step(4);
        chk("scan_e8_an", {12'd0, bus.AN}, 16'h000B);
        step(4);
        chk("scan_e12_an", {12'd0, bus.AN}, 16'h0007);
        step(3);
        chk("scan_e15_sel", {14'd0, bus.S1, bus.S0}, 16'd3);
        chk("scan_e15_ft", {15'd0, bus.frame_tick}, 16'd0);
        step(1);
        chk("scan_e16_ft", {15'd0, bus.frame_tick}, 16'd1);
        chk("scan_e16_an", {12'd0, bus.AN}, 16'h000E);

        // 3: write a2=A during slot 1, visible only at the wrap (edge 32)
        exp_q.push_back(16'h0A00);
        step(4);
        wr(2'd2, 4'hA);
        step(1);
        bus.wr_en = 1'b0;
        chk("wr_a2_pending", {12'd0, bus.a2}, 16'h0000);
        step(10);
        chk("wr_a2_e31", {12'd0, bus.a2}, 16'h0000);
        step(1);
        chk("wr_a2_commit", {12'd0, bus.a2}, 16'h000A);
        chk("wr_a2_ft", {15'd0, bus.frame_tick}, 16'd1);

        // 4: write in the commit cycle (before edge 48), then 6 then 7 in frame 4
        exp_q.push_back(16'h0A05);
        exp_q.push_back(16'h0A07);
        step(15);
        wr(2'd0, 4'h5);
        step(1);
        bus.wr_en = 1'b0;
        chk("commit_cycle_a0", {12'd0, bus.a0}, 16'h0005);
        step(2);
        wr(2'd0, 4'h6);
        step(1);
        wr(2'd0, 4'h7);
        step(1);
        bus.wr_en = 1'b0;
        chk("no_tear_a0", {12'd0, bus.a0}, 16'h0005);
        step(12);
        chk("last_wins_a0", {12'd0, bus.a0}, 16'h0007);

        // 5: freeze at idx=2, presc=1 (after edge 73) for 10 clks
        exp_q.push_back(16'h0A07);
        step(9);
        bus.en = 1'b0;
        step(1);
        chk("blank_an", {12'd0, bus.AN}, 16'h000F);
        chk("blank_sel", {14'd0, bus.S1, bus.S0}, 16'd2);
        step(9);
        chk("blank_hold_an", {12'd0, bus.AN}, 16'h000F);
        chk("blank_hold_sel", {14'd0, bus.S1, bus.S0}, 16'd2);
        chk("blank_hold_ft", {15'd0, bus.frame_tick}, 16'd0);
        bus.en = 1'b1;
        step(1);
        chk("resume_an", {12'd0, bus.AN}, 16'h000B);
        step(1);
        chk("resume_an2", {12'd0, bus.AN}, 16'h000B);
        step(1);
        chk("resume_slot_end", {12'd0, bus.AN}, 16'h0007);
        step(4);
        chk("resume_frame_ft", {15'd0, bus.frame_tick}, 16'd1);

        // 6: async reset mid-frame with pending writes
        step(2);
        wr(2'd1, 4'h3);
        step(1);
        wr(2'd3, 4'h9);
        step(1);
        bus.wr_en = 1'b0;
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bank", {bus.a3, bus.a2, bus.a1, bus.a0}, 16'h0000);
        chk("mid_rst_sel", {14'd0, bus.S1, bus.S0}, 16'd0);
        chk("mid_rst_an", {12'd0, bus.AN}, 16'h000F);
        chk("mid_rst_ft", {15'd0, bus.frame_tick}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(16'h0000);
        step(15);
        chk("post_rst_e15_ft", {15'd0, bus.frame_tick}, 16'd0);
        step(1);
        chk("post_rst_ft", {15'd0, bus.frame_tick}, 16'd1);
        chk("post_rst_bank", {bus.a3, bus.a2, bus.a1, bus.a0}, 16'h0000);
        step(4);

        chk("frames_pending", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
